// File: rtl/mc_ctrl_if.sv
// rtl/mc_ctrl_if.sv - control/handshake bundle between the multi-cycle sequencer and the datapath
interface mc_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             run;
    logic [5:0]       opcode;
    logic             mem_ready;
    logic             pc_write;
    logic             pc_write_cond;
    logic             i_or_d;
    logic             mem_read;
    logic             mem_write;
    logic             ir_write;
    logic             mem_to_reg;
    logic             reg_dst;
    logic             reg_write;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       alu_op;
    logic [1:0]       pc_source;
    logic [3:0]       state;
    logic             illegal_op;
    logic             mem_timeout;
    logic [CNT_W-1:0] retired;

    // Sequencer side
    modport master (
        input  run, opcode, mem_ready,
        output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, state, illegal_op, mem_timeout, retired
    );

    // Datapath / memory side
    modport slave (
        output run, opcode, mem_ready,
        input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, state, illegal_op, mem_timeout, retired
    );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// rtl/mc_ctrl_fsm.sv - multi-cycle MIPS-subset control sequencer with memory wait timeout
module mc_ctrl_fsm #(
    parameter int CNT_W      = 16,
    parameter int WAIT_LIMIT = 15
) (
    input  logic      clk,
    input  logic      rst_n,
    mc_ctrl_if.master bus
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_RTEX   = 4'd6,
        S_RTWB   = 4'd7,
        S_BEQEX  = 4'd8
    } state_t;

    typedef enum logic [2:0] {
        CLS_NONE = 3'd0,
        CLS_R    = 3'd1,
        CLS_LW   = 3'd2,
        CLS_SW   = 3'd3,
        CLS_BEQ  = 3'd4
    } op_class_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    // Counter value seen during the last permitted wait cycle.
    localparam logic [7:0] WAIT_LAST = 8'(WAIT_LIMIT - 1);

    state_t           state_q, state_d;
    op_class_t        cls_q, cls_d;
    logic [7:0]       wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0] retired_q;
    logic             gap_q;

    logic       waiting, retire, timeout, fetch_req;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
    logic [1:0] alu_src_b, alu_op, pc_source;

    // State, opcode class, wait counter, retire count and post-timeout gap flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_FETCH;
            cls_q      <= CLS_NONE;
            wait_cnt_q <= 8'd0;
            retired_q  <= '0;
            gap_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cls_q      <= cls_d;
            wait_cnt_q <= wait_cnt_d;
            gap_q      <= timeout;
            if (retire) begin
                retired_q <= retired_q + CNT_W'(1);
            end
        end
    end

    // Next-state and per-step datapath controls
    always_comb begin
        state_d       = state_q;
        cls_d         = cls_q;
        waiting       = 1'b0;
        retire        = 1'b0;
        fetch_req     = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        illegal_op    = 1'b0;

        case (state_q)
            S_FETCH: begin
                // The cycle after a timeout keeps the request low so the
                // memory sees the aborted access end before a new one starts.
                fetch_req = bus.run & ~gap_q;
                mem_read  = fetch_req;
                alu_src_b = 2'b01;
                waiting   = fetch_req;
                if (fetch_req && bus.mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (bus.opcode)
                    OP_RTYPE: begin cls_d = CLS_R;   state_d = S_RTEX;   end
                    OP_LW:    begin cls_d = CLS_LW;  state_d = S_MEMADR; end
                    OP_SW:    begin cls_d = CLS_SW;  state_d = S_MEMADR; end
                    OP_BEQ:   begin cls_d = CLS_BEQ; state_d = S_BEQEX;  end
                    default: begin
                        cls_d      = CLS_NONE;
                        illegal_op = 1'b1;
                        state_d    = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (cls_q == CLS_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                waiting  = 1'b1;
                if (bus.mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = S_FETCH;
                retire     = 1'b1;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                waiting   = 1'b1;
                if (bus.mem_ready) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end
            end
            S_RTEX: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                state_d   = S_RTWB;
            end
            S_RTWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                state_d   = S_FETCH;
                retire    = 1'b1;
            end
            S_BEQEX: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                state_d       = S_FETCH;
                retire        = 1'b1;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        // mem_ready on the limit cycle wins because timeout needs it low.
        timeout = waiting & ~bus.mem_ready & (wait_cnt_q == WAIT_LAST);
        if (timeout) begin
            state_d = S_FETCH;
        end

        if (timeout || bus.mem_ready || !waiting || (state_d != state_q)) begin
            wait_cnt_d = 8'd0;
        end else begin
            wait_cnt_d = wait_cnt_q + 8'd1;
        end
    end

    // Controls are forced low while reset is held so an access aborts at once
    assign bus.pc_write      = pc_write & rst_n;
    assign bus.pc_write_cond = pc_write_cond & rst_n;
    assign bus.i_or_d        = i_or_d & rst_n;
    assign bus.mem_read      = mem_read & rst_n;
    assign bus.mem_write     = mem_write & rst_n;
    assign bus.ir_write      = ir_write & rst_n;
    assign bus.mem_to_reg    = mem_to_reg & rst_n;
    assign bus.reg_dst       = reg_dst & rst_n;
    assign bus.reg_write     = reg_write & rst_n;
    assign bus.alu_src_a     = alu_src_a & rst_n;
    assign bus.alu_src_b     = rst_n ? alu_src_b : 2'b00;
    assign bus.alu_op        = rst_n ? alu_op : 2'b00;
    assign bus.pc_source     = rst_n ? pc_source : 2'b00;
    assign bus.illegal_op    = illegal_op & rst_n;
    assign bus.mem_timeout   = timeout & rst_n;
    assign bus.state         = state_q;
    assign bus.retired       = retired_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb/tb_mc_ctrl_fsm.sv - directed self-checking bench for mc_ctrl_fsm
module tb_mc_ctrl_fsm;

    logic       clk;
    logic       rst_n;
    logic       run;
    logic [5:0] opcode;
    logic       mem_ready;

    int checks = 0;
    int fails  = 0;

    mc_ctrl_if #(.CNT_W(16)) bus16 ();
    mc_ctrl_if #(.CNT_W(4))  bus4 ();

    assign bus16.run       = run;
    assign bus16.opcode    = opcode;
    assign bus16.mem_ready = mem_ready;
    assign bus4.run        = run;
    assign bus4.opcode     = opcode;
    assign bus4.mem_ready  = mem_ready;

    mc_ctrl_fsm #(.CNT_W(16), .WAIT_LIMIT(15)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus16)
    );

    mc_ctrl_fsm #(.CNT_W(4), .WAIT_LIMIT(15)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        run       = 1'b0;
        mem_ready = 1'b0;
        opcode    = 6'b000000;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        run       = 1'b1;
        mem_ready = 1'b1;
        opcode    = 6'b000000;
        #3;
        checks++;
        if (bus16.state !== 4'd0) begin
            fails++; $display("FAIL reset_state: got %0d expected 0", bus16.state);
        end
        checks++;
        if ({bus16.mem_read, bus16.ir_write, bus16.pc_write, bus16.alu_src_b} !== 5'b00000) begin
            fails++; $display("FAIL reset_ctrl: got %b expected 00000",
                {bus16.mem_read, bus16.ir_write, bus16.pc_write, bus16.alu_src_b});
        end
        checks++;
        if (bus16.retired !== 16'd0 || bus4.retired !== 4'd0) begin
            fails++; $display("FAIL reset_retired: got %0d/%0d expected 0/0", bus16.retired, bus4.retired);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_rtype();
        logic [3:0] exp_st [5] = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0};
        do_reset();
        run = 1'b1; mem_ready = 1'b1; opcode = 6'b000000;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (bus16.state !== exp_st[i]) begin
                fails++; $display("FAIL rtype_state[%0d]: got %0d expected %0d", i, bus16.state, exp_st[i]);
            end
            if (i == 0) begin
                checks++;
                if ({bus16.mem_read, bus16.ir_write, bus16.pc_write, bus16.alu_src_b} !== 5'b11101) begin
                    fails++; $display("FAIL rtype_fetch: got %b expected 11101",
                        {bus16.mem_read, bus16.ir_write, bus16.pc_write, bus16.alu_src_b});
                end
            end
            if (i == 2) begin
                checks++;
                if ({bus16.alu_src_a, bus16.alu_src_b, bus16.alu_op} !== 5'b10010) begin
                    fails++; $display("FAIL rtype_ex: got %b expected 10010",
                        {bus16.alu_src_a, bus16.alu_src_b, bus16.alu_op});
                end
            end
            if (i == 3) begin
                checks++;
                if ({bus16.reg_write, bus16.reg_dst, bus16.mem_to_reg} !== 3'b110) begin
                    fails++; $display("FAIL rtype_wb: got %b expected 110",
                        {bus16.reg_write, bus16.reg_dst, bus16.mem_to_reg});
                end
            end
            tick();
        end
        checks++;
        if (bus16.retired !== 16'd1) begin
            fails++; $display("FAIL rtype_retired: got %0d expected 1", bus16.retired);
        end
    endtask

    task automatic test_lw_wait();
        logic [3:0] exp_st [9] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3, 4'd4, 4'd0};
        logic       rdy    [9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        int rd_cycles = 0;
        do_reset();
        run = 1'b1; opcode = 6'b100011;
        for (int i = 0; i < 9; i++) begin
            mem_ready = rdy[i];
            #1;
            checks++;
            if (bus16.state !== exp_st[i]) begin
                fails++; $display("FAIL lw_state[%0d]: got %0d expected %0d", i, bus16.state, exp_st[i]);
            end
            if (bus16.state == 4'd3 && bus16.mem_read === 1'b1 && bus16.i_or_d === 1'b1) rd_cycles++;
            if (i == 7) begin
                checks++;
                if ({bus16.reg_write, bus16.mem_to_reg, bus16.reg_dst} !== 3'b110) begin
                    fails++; $display("FAIL lw_memwb: got %b expected 110",
                        {bus16.reg_write, bus16.mem_to_reg, bus16.reg_dst});
                end
            end
            tick();
        end
        checks++;
        if (rd_cycles != 4) begin
            fails++; $display("FAIL lw_read_cycles: got %0d expected 4", rd_cycles);
        end
        checks++;
        if (bus16.retired !== 16'd1) begin
            fails++; $display("FAIL lw_retired: got %0d expected 1", bus16.retired);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_st [8] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0, 4'd1, 4'd8, 4'd0};
        do_reset();
        run = 1'b1; mem_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            opcode = (i < 4) ? 6'b101011 : 6'b000100;
            #1;
            checks++;
            if (bus16.state !== exp_st[i]) begin
                fails++; $display("FAIL b2b_state[%0d]: got %0d expected %0d", i, bus16.state, exp_st[i]);
            end
            if (i == 3) begin
                checks++;
                if ({bus16.mem_write, bus16.i_or_d, bus16.mem_read} !== 3'b110) begin
                    fails++; $display("FAIL b2b_memwr: got %b expected 110",
                        {bus16.mem_write, bus16.i_or_d, bus16.mem_read});
                end
            end
            if (i == 6) begin
                checks++;
                if ({bus16.alu_op, bus16.pc_write_cond, bus16.pc_source, bus16.alu_src_a} !== 6'b011011) begin
                    fails++; $display("FAIL b2b_beqex: got %b expected 011011",
                        {bus16.alu_op, bus16.pc_write_cond, bus16.pc_source, bus16.alu_src_a});
                end
            end
            tick();
        end
        checks++;
        if (bus16.retired !== 16'd2) begin
            fails++; $display("FAIL b2b_retired: got %0d expected 2", bus16.retired);
        end
    endtask

    task automatic test_illegal();
        do_reset();
        run = 1'b1; mem_ready = 1'b1; opcode = 6'b111111;
        tick();
        #1;
        checks++;
        if (bus16.state !== 4'd1 || bus16.illegal_op !== 1'b1) begin
            fails++; $display("FAIL illegal_decode: got state %0d pulse %b expected 1/1", bus16.state, bus16.illegal_op);
        end
        tick();
        run = 1'b0;
        #1;
        checks++;
        if (bus16.state !== 4'd0 || bus16.illegal_op !== 1'b0) begin
            fails++; $display("FAIL illegal_next: got state %0d pulse %b expected 0/0", bus16.state, bus16.illegal_op);
        end
        checks++;
        if (bus16.retired !== 16'd0) begin
            fails++; $display("FAIL illegal_retired: got %0d expected 0", bus16.retired);
        end
    endtask

    task automatic test_timeout();
        logic saw_wr = 1'b0;
        do_reset();
        run = 1'b1; mem_ready = 1'b1; opcode = 6'b100011;
        repeat (3) tick();
        mem_ready = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            #1;
            checks++;
            if (bus16.state !== 4'd3 || bus16.mem_timeout !== (k == 15)) begin
                fails++; $display("FAIL timeout_wait[%0d]: got state %0d pulse %b expected 3/%0d",
                    k, bus16.state, bus16.mem_timeout, (k == 15));
            end
            if (bus16.reg_write !== 1'b0) saw_wr = 1'b1;
            tick();
        end
        #1;
        checks++;
        if (bus16.state !== 4'd0 || bus16.mem_read !== 1'b0 || bus16.mem_timeout !== 1'b0) begin
            fails++; $display("FAIL timeout_after: got state %0d rd %b pulse %b expected 0/0/0",
                bus16.state, bus16.mem_read, bus16.mem_timeout);
        end
        if (bus16.reg_write !== 1'b0) saw_wr = 1'b1;
        checks++;
        if (saw_wr !== 1'b0 || bus16.retired !== 16'd0) begin
            fails++; $display("FAIL timeout_nowb: got wr %b retired %0d expected 0/0", saw_wr, bus16.retired);
        end
        tick();
        #1;
        checks++;
        if (bus16.state !== 4'd0 || bus16.mem_read !== 1'b1) begin
            fails++; $display("FAIL timeout_refetch: got state %0d rd %b expected 0/1", bus16.state, bus16.mem_read);
        end
    endtask

    task automatic test_ready_at_limit();
        do_reset();
        run = 1'b1; mem_ready = 1'b1; opcode = 6'b100011;
        repeat (3) tick();
        mem_ready = 1'b0;
        repeat (14) tick();
        mem_ready = 1'b1;
        #1;
        checks++;
        if (bus16.state !== 4'd3 || bus16.mem_timeout !== 1'b0) begin
            fails++; $display("FAIL limit_ready: got state %0d pulse %b expected 3/0", bus16.state, bus16.mem_timeout);
        end
        tick();
        #1;
        checks++;
        if (bus16.state !== 4'd4 || bus16.reg_write !== 1'b1) begin
            fails++; $display("FAIL limit_memwb: got state %0d wr %b expected 4/1", bus16.state, bus16.reg_write);
        end
    endtask

    task automatic test_reset_mid_write();
        do_reset();
        run = 1'b1; mem_ready = 1'b1; opcode = 6'b000000;
        repeat (4) tick();
        opcode = 6'b101011;
        repeat (3) tick();
        mem_ready = 1'b0;
        repeat (2) tick();
        #1;
        checks++;
        if (bus16.state !== 4'd5 || bus16.mem_write !== 1'b1 || bus16.retired !== 16'd1) begin
            fails++; $display("FAIL rstwr_pre: got state %0d wr %b retired %0d expected 5/1/1",
                bus16.state, bus16.mem_write, bus16.retired);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus16.mem_write !== 1'b0 || bus16.i_or_d !== 1'b0 || bus16.state !== 4'd0 || bus16.retired !== 16'd0) begin
            fails++; $display("FAIL rstwr_abort: got wr %b addr %b state %0d retired %0d expected 0/0/0/0",
                bus16.mem_write, bus16.i_or_d, bus16.state, bus16.retired);
        end
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_wrap();
        do_reset();
        run = 1'b1; mem_ready = 1'b1; opcode = 6'b000000;
        repeat (60) tick();
        checks++;
        if (bus4.retired !== 4'd15 || bus16.retired !== 16'd15) begin
            fails++; $display("FAIL wrap_15: got %0d/%0d expected 15/15", bus4.retired, bus16.retired);
        end
        repeat (4) tick();
        checks++;
        if (bus4.retired !== 4'd0 || bus16.retired !== 16'd16) begin
            fails++; $display("FAIL wrap_16: got %0d/%0d expected 0/16", bus4.retired, bus16.retired);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        run       = 1'b0;
        mem_ready = 1'b0;
        opcode    = 6'b000000;
        test_reset();
        test_rtype();
        test_lw_wait();
        test_back_to_back();
        test_illegal();
        test_timeout();
        test_ready_at_limit();
        test_reset_mid_write();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
- Multi-cycle control sequencer for the MIPS-subset datapath: R-type (000000), lw (100011), sw (101011) and beq (000100).
- Replaces single-cycle decode with a state machine that issues per-step datapath controls.
- Waits on a memory ready handshake, with a timeout.
- Counts retired instructions.
- Sits between the instruction register opcode field and the shared PC/ALU/register-file/memory datapath.

Parameters:
- CNT_W, 16, width of the retired-instruction counter.
- WAIT_LIMIT, 15, maximum wait cycles in any memory state before timeout (1..255).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- run  in  1  permits a new fetch
- opcode  in  6  IR[31:26]; valid from the DECODE cycle onward
- mem_ready  in  1  memory completes the current access this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if ALU zero
- i_or_d  out  1  memory address select, 0=PC, 1=ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  IR load
- mem_to_reg  out  1  write-back data select, 1=MDR
- reg_dst  out  1  write register select, 1=rd
- reg_write  out  1  register file write
- alu_src_a  out  1  ALU A select, 0=PC, 1=rs
- alu_src_b  out  2  ALU B select: 00 rt, 01 const 4, 10 sign-ext imm, 11 imm<<2
- alu_op  out  2  00 add, 01 sub, 10 use funct
- pc_source  out  2  PC source: 00 ALU, 01 ALUOut
- state  out  4  current state encoding
- illegal_op  out  1  one-cycle pulse
- mem_timeout  out  1  one-cycle pulse
- retired  out  CNT_W  retired-instruction count

Behaviour:
- Reset: state=FETCH, latched opcode class=0, wait counter=0, retired=0. While rst_n is low, every control output and pulse is 0. Reset mid-access aborts the access immediately.
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTEX=6, RTWB=7, BEQEX=8.
- Unlisted outputs are 0 in each state. All outputs are Moore unless marked as qualified by mem_ready.
- FETCH:
  - mem_read=run, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write=pc_write=run&mem_ready.
  - Goes to DECODE when run&mem_ready. If run=0: idle, no request, wait counter held at 0.
- DECODE:
  - alu_src_a=0, alu_src_b=11, alu_op=00.
  - Latches the opcode class.
  - Next state: lw/sw to MEMADR, R-type to RTEX, beq to BEQEX.
  - Any other opcode: illegal_op=1 this cycle, next state FETCH, retired unchanged.
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Next state MEMRD for lw, MEMWR for sw.
- MEMRD: mem_read=1, i_or_d=1. Goes to MEMWB on mem_ready.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0. Next state FETCH; retired+1.
- MEMWR: mem_write=1, i_or_d=1. On mem_ready: next state FETCH; retired+1.
- RTEX: alu_src_a=1, alu_src_b=00, alu_op=10. Next state RTWB.
- RTWB: reg_write=1, reg_dst=1, mem_to_reg=0. Next state FETCH; retired+1.
- BEQEX: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01. Next state FETCH; retired+1.
- Wait counter, used in memory states (FETCH with run=1, MEMRD, MEMWR):
  - Counts consecutive cycles without mem_ready.
  - Clears on mem_ready or on state change.
  - If the count reaches WAIT_LIMIT with mem_ready still 0: mem_timeout=1 that cycle, the request drops next cycle, next state FETCH, no retire, no write-back.
  - mem_ready in the same cycle as the limit wins: the access completes normally.
- retired wraps from 2^CNT_W-1 to 0.
- Unused encodings 9-15 go to FETCH next cycle with all outputs 0.

Test Plan:
- Reset release, run=1, mem_ready=1 always, opcode=000000 -> states 0,1,6,7,0; rtwb asserts reg_write=1, reg_dst=1; retired=1.
- lw with mem_ready low 3 cycles in MEMRD -> states 0,1,2,3,3,3,3,4,0; mem_read held 4 cycles; mem_to_reg=1 in MEMWB; retired=1.
- sw then beq, ready=1 -> MEMWR: mem_write=1, i_or_d=1. BEQEX: alu_op=01, pc_write_cond=1, pc_source=01. retired=2.
- opcode=111111 at DECODE -> illegal_op pulses 1 cycle; next state 0; retired unchanged.
- WAIT_LIMIT=15, mem_ready=0 in MEMRD -> mem_timeout on the 15th wait cycle; next state 0; no reg_write.
- rst_n low during MEMWR -> mem_write=0 immediately; state=0; retired=0.
- CNT_W=4, 16 R-types -> retired wraps to 0.
